// File: rtl/l2_bridge_pkg.sv
// Shared types and constants for the L2 burst bridge: FSM states,
// beat-count type and the fixed byte-enable / address-step values.
package l2_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_ERROR = 3'd4
   } bridge_state_t;

   // Holds 1..256 beats, so one bit wider than the command length field.
   typedef logic [8:0] beat_cnt_t;

   localparam logic [3:0]  BE_ALL   = 4'hF;
   localparam logic [31:0] ADDR_INC = 32'd4;

   // Command length is encoded as beats minus one.
   function automatic beat_cnt_t len_to_beats(input logic [7:0] len);
      return beat_cnt_t'({1'b0, len}) + 9'd1;
   endfunction

endpackage

// File: rtl/l2_bridge_rd_fifo.sv
// Read-return buffer: circular FIFO with occupancy count. A push and a
// pop in the same cycle are both honoured when the buffer is full.
module l2_bridge_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wptr_r;
   logic [AW-1:0]    rptr_r;
   logic [CW-1:0]    count_r;
   logic             do_pop_s;
   logic             do_push_s;

   assign do_pop_s  = pop_i & (count_r != CW'(0));
   assign do_push_s = push_i & ((count_r != CW'(DEPTH)) | do_pop_s);

   assign dout_o  = mem_r[rptr_r];
   assign empty_o = (count_r == CW'(0));
   assign count_o = count_r;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_r  <= AW'(0);
         rptr_r  <= AW'(0);
         count_r <= CW'(0);
      end else begin
         if (do_push_s) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset because the count gates validity.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_r[wptr_r] <= din_i;
      end
   end

endmodule

// File: rtl/l2_burst_bridge.sv
// Bridges burst commands from the JTAG-side access engine onto the L2
// TCDM port: one request per beat, credit-limited reads into a small
// return buffer, and a one-cycle error pulse for misaligned commands.
module l2_burst_bridge
   import l2_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic                  cmd_we_i,
   input  logic [7:0]            cmd_len_i,
   input  logic                  wdata_valid_i,
   output logic                  wdata_ready_o,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rdata_valid_o,
   input  logic                  rdata_ready_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int CW    = $clog2(RD_FIFO_DEPTH) + 1;
   localparam int SUM_W = CW + 1;

   bridge_state_t         state_r;
   bridge_state_t         state_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   beat_cnt_t             beats_r;
   logic [CW-1:0]         outst_r;

   logic [CW-1:0]         fifo_count_s;
   logic                  fifo_empty_s;
   logic [SUM_W-1:0]      credit_sum_s;
   logic                  credit_s;
   logic                  grant_s;
   logic                  last_beat_s;
   logic                  accept_s;
   logic                  rsp_push_s;
   logic                  rd_issue_s;

   assign credit_sum_s = SUM_W'(outst_r) + SUM_W'(fifo_count_s);
   assign credit_s     = (credit_sum_s < SUM_W'(RD_FIFO_DEPTH));
   assign grant_s      = mem_req_o & mem_gnt_i;
   assign last_beat_s  = (beats_r == 9'd1);
   assign accept_s     = cmd_valid_i & (state_r == ST_IDLE);
   assign rd_issue_s   = grant_s & (state_r == ST_READ);
   assign rsp_push_s   = mem_rvalid_i & ((state_r == ST_READ) | (state_r == ST_DRAIN));
   assign mem_addr_o   = addr_r;
   assign rdata_valid_o = ~fifo_empty_s;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and memory/stream handshake outputs.
   always_comb begin
      state_s       = state_r;
      cmd_ready_o   = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_be_o      = 4'h0;
      mem_wdata_o   = '0;
      wdata_ready_o = 1'b0;
      busy_o        = 1'b1;
      err_o         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (cmd_valid_i) begin
               if (cmd_addr_i[1:0] != 2'b00) begin
                  state_s = ST_ERROR;
               end else if (cmd_we_i) begin
                  state_s = ST_WRITE;
               end else begin
                  state_s = ST_READ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            // Write data flows straight through; one beat per grant.
            mem_req_o     = wdata_valid_i;
            mem_we_o      = 1'b1;
            mem_be_o      = BE_ALL;
            mem_wdata_o   = wdata_i;
            wdata_ready_o = wdata_valid_i & mem_gnt_i;
            if (wdata_valid_i & mem_gnt_i & last_beat_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_READ: begin
            // Only request when a buffer slot is guaranteed for the response.
            mem_req_o = credit_s;
            mem_be_o  = BE_ALL;
            if (credit_s & mem_gnt_i & last_beat_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if ((outst_r == CW'(0)) & fifo_empty_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_ERROR: begin
            err_o   = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Burst address and remaining-beat counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_r  <= '0;
         beats_r <= 9'd0;
      end else if (accept_s) begin
         addr_r  <= cmd_addr_i;
         beats_r <= len_to_beats(cmd_len_i);
      end else if (grant_s) begin
         addr_r  <= addr_r + ADDR_WIDTH'(ADDR_INC);
         beats_r <= beats_r - 9'd1;
      end else begin
         addr_r  <= addr_r;
         beats_r <= beats_r;
      end
   end

   // Count of granted reads whose responses have not yet returned.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outst_r <= CW'(0);
      end else begin
         case ({rd_issue_s, rsp_push_s})
            2'b10:   outst_r <= outst_r + CW'(1);
            2'b01:   outst_r <= outst_r - CW'(1);
            default: outst_r <= outst_r;
         endcase
      end
   end

   l2_bridge_rd_fifo #(
      .DEPTH (RD_FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_rd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rsp_push_s),
      .din_i   (mem_rdata_i),
      .pop_i   (rdata_ready_i),
      .dout_o  (rdata_o),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

endmodule

// File: tb/tb_l2_burst_bridge.sv
// Self-checking bench for l2_burst_bridge: directed scenarios followed by
// randomized bursts, with a behavioural L2 memory and an expected-memory model.
module tb_l2_burst_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
   logic [31:0] cmd_addr_i;
   logic [7:0]  cmd_len_i;
   logic        wdata_valid_i, wdata_ready_o;
   logic [31:0] wdata_i;
   logic        rdata_valid_o, rdata_ready_i;
   logic [31:0] rdata_o;
   logic        mem_req_o, mem_gnt_i, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o, err_o;

   always #5 clk_i = ~clk_i;

   l2_burst_bridge dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
      .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i),
      .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
      .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural L2 memory ----------------
   typedef struct { logic [31:0] data; int due; } rsp_t;

   logic [31:0] store   [logic [31:0]];
   logic [31:0] exp_mem [logic [31:0]];
   logic [31:0] gnt_addr_q[$];
   logic        gnt_we_q[$];
   rsp_t        rsp_q[$];
   int          gnt_mode = 0;   // 0 always grant, 1 random, 2 three wait cycles
   int          lat_min = 1, lat_max = 1;
   int          cyc = 0, last_due = 0, hold_cnt = 0;
   int          rvalid_cnt = 0, err_seen = 0;
   logic        prev_pend = 1'b0, prev_we;
   logic [31:0] prev_addr, prev_wdata;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hC3A5_0F1E;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
   endfunction

   initial begin : mem_side
      rsp_t r;
      int   d;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rsp_q[0].data;
            void'(rsp_q.pop_front());
            rvalid_cnt++;
         end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
         end
         case (gnt_mode)
            0:       mem_gnt_i = 1'b1;
            1:       mem_gnt_i = 1'($urandom_range(0, 1));
            default: mem_gnt_i = (hold_cnt >= 3);
         endcase
         #1;
         if (err_o) err_seen++;
         if (prev_pend) begin
            chk1("req_held", mem_req_o, 1'b1);
            chk("addr_stable", mem_addr_o, prev_addr);
            chk1("we_stable", mem_we_o, prev_we);
            if (prev_we) chk("wdata_stable", mem_wdata_o, prev_wdata);
         end
         if (mem_req_o && mem_gnt_i) begin
            gnt_addr_q.push_back(mem_addr_o);
            gnt_we_q.push_back(mem_we_o);
            if (mem_we_o) begin
               store[mem_addr_o] = mem_wdata_o;
            end else begin
               d = cyc + int'($urandom_range(lat_min, lat_max));
               if (d <= last_due) d = last_due + 1;
               last_due = d;
               r.data = store.exists(mem_addr_o) ? store[mem_addr_o] : dflt(mem_addr_o);
               r.due  = d;
               rsp_q.push_back(r);
            end
            hold_cnt  = 0;
            prev_pend = 1'b0;
         end else if (mem_req_o) begin
            hold_cnt++;
            prev_pend  = 1'b1;
            prev_addr  = mem_addr_o;
            prev_we    = mem_we_o;
            prev_wdata = mem_wdata_o;
         end else begin
            prev_pend = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   logic [31:0] last_rdata;

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   task automatic settle();
      @(negedge clk_i); #2;
   endtask

   task automatic issue(input logic [31:0] a, input logic we, input logic [7:0] len);
      logic ok = 1'b0;
      cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_len_i = len;
      for (int t = 0; t < 100 && !ok; t++) begin
         settle();
         ok = cmd_ready_o;
         tick();
      end
      cmd_valid_i = 1'b0;
      chk1("cmd_accept", ok, 1'b1);
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int t = 0; t < 600 && !ok; t++) begin
         settle();
         ok = cmd_ready_o;
         tick();
      end
      chk1("idle_reached", ok, 1'b1);
   endtask

   task automatic check_addrs(input logic [31:0] a, input int n, input logic we);
      chk("gnt_count", 32'(gnt_addr_q.size()), 32'(n));
      for (int i = 0; i < n && i < gnt_addr_q.size(); i++) begin
         chk("gnt_addr", gnt_addr_q[i], a + 32'(4 * i));
         chk1("gnt_we", gnt_we_q[i], we);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input int n, input bit bubbles,
                           input bit use_fixed, input logic [31:0] fixed_data);
      logic        got;
      logic [31:0] data;
      gnt_addr_q.delete(); gnt_we_q.delete();
      issue(a, 1'b1, 8'(n - 1));
      for (int i = 0; i < n; i++) begin
         if (bubbles && $urandom_range(0, 3) == 0) begin
            wdata_valid_i = 1'b0;
            tick();
         end
         data = use_fixed ? fixed_data : $urandom;
         wdata_valid_i = 1'b1;
         wdata_i = data;
         got = 1'b0;
         for (int t = 0; t < 200 && !got; t++) begin
            settle();
            got = wdata_ready_o;
            tick();
         end
         chk1("wbeat_taken", got, 1'b1);
         exp_mem[a + 32'(4 * i)] = data;
      end
      wdata_valid_i = 1'b0;
      wdata_i = 32'h0;
      wait_idle();
      check_addrs(a, n, 1'b1);
   endtask

   task automatic collect(input logic [31:0] a, input int n, input bit rnd_ready);
      int cnt = 0;
      for (int t = 0; t < 4000 && cnt < n; t++) begin
         rdata_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         settle();
         if (rdata_valid_o && rdata_ready_i) begin
            chk("rdata", rdata_o, model_rd(a + 32'(4 * cnt)));
            last_rdata = rdata_o;
            cnt++;
         end
         tick();
      end
      rdata_ready_i = 1'b0;
      chk("rbeats", 32'(cnt), 32'(n));
      wait_idle();
      settle();
      chk1("no_extra_rdata", rdata_valid_o, 1'b0);
      tick();
      check_addrs(a, n, 1'b0);
   endtask

   task automatic do_read(input logic [31:0] a, input int n, input bit rnd_ready);
      gnt_addr_q.delete(); gnt_we_q.delete();
      issue(a, 1'b0, 8'(n - 1));
      collect(a, n, rnd_ready);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin : main
      logic [31:0] r, a, last_wr_a;
      int          n, base, last_wr_n;
      logic        seen;
      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = 32'h0; cmd_we_i = 1'b0; cmd_len_i = 8'h0;
      wdata_valid_i = 1'b0; wdata_i = 32'h0; rdata_ready_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      settle();
      chk1("rst_cmd_ready", cmd_ready_o, 1'b1);
      chk1("rst_mem_req", mem_req_o, 1'b0);
      chk1("rst_wdata_ready", wdata_ready_o, 1'b0);
      chk1("rst_rdata_valid", rdata_valid_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_err", err_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_mem_wdata", mem_wdata_o, 32'h0);
      chk("rst_mem_be", 32'(mem_be_o), 32'h0);
      tick();

      // single write then single read back
      do_write(32'h0000_0000, 1, 1'b0, 1'b1, 32'hABBA_ABBA);
      do_read(32'h0000_0000, 1, 1'b0);
      chk("single_rdback", last_rdata, 32'hABBA_ABBA);
      chk("no_err_pulse", 32'(err_seen), 32'h0);

      // 4-beat write, each beat waits three ungranted cycles
      gnt_mode = 2;
      do_write(32'h0000_1000, 4, 1'b0, 1'b0, 32'h0);
      gnt_mode = 0;

      // 8-beat read with consumer stalled: credit limits to 4 grants
      lat_min = 1; lat_max = 2;
      gnt_addr_q.delete(); gnt_we_q.delete();
      rdata_ready_i = 1'b0;
      issue(32'h0000_2000, 1'b0, 8'd7);
      repeat (20) tick();
      settle();
      chk("stall_gnt_count", 32'(gnt_addr_q.size()), 32'd4);
      chk1("stall_req_low", mem_req_o, 1'b0);
      chk1("stall_rdata_valid", rdata_valid_o, 1'b1);
      tick();
      collect(32'h0000_2000, 8, 1'b0);

      // address wrap at the top of the space
      do_read(32'hFFFF_FFFC, 2, 1'b0);

      // misaligned command: one-cycle error, nothing issued or consumed
      gnt_addr_q.delete(); gnt_we_q.delete();
      wdata_valid_i = 1'b1; wdata_i = 32'h1234_5678;
      cmd_valid_i = 1'b1; cmd_addr_i = 32'h0000_0002; cmd_we_i = 1'b1; cmd_len_i = 8'd0;
      settle();
      chk1("mis_ready_before", cmd_ready_o, 1'b1);
      tick();
      cmd_valid_i = 1'b0;
      settle();
      chk1("mis_err_pulse", err_o, 1'b1);
      chk1("mis_busy", busy_o, 1'b1);
      chk1("mis_no_req", mem_req_o, 1'b0);
      chk1("mis_no_wready", wdata_ready_o, 1'b0);
      chk1("mis_not_ready", cmd_ready_o, 1'b0);
      tick();
      settle();
      chk1("mis_err_clear", err_o, 1'b0);
      chk1("mis_ready_after", cmd_ready_o, 1'b1);
      chk1("mis_no_req2", mem_req_o, 1'b0);
      tick();
      wdata_valid_i = 1'b0;
      chk("mis_no_grants", 32'(gnt_addr_q.size()), 32'h0);

      // reset during beat 3 of a 16-beat read
      lat_min = 2; lat_max = 2;
      gnt_addr_q.delete(); gnt_we_q.delete();
      rdata_ready_i = 1'b0;
      issue(32'h0000_3000, 1'b0, 8'd15);
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
         settle();
         seen = (gnt_addr_q.size() >= 3);
         tick();
      end
      chk1("beat3_reached", seen, 1'b1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      base = rvalid_cnt;
      settle();
      chk1("mrst_idle", cmd_ready_o, 1'b1);
      chk1("mrst_busy", busy_o, 1'b0);
      chk1("mrst_fifo_empty", rdata_valid_o, 1'b0);
      chk1("mrst_no_req", mem_req_o, 1'b0);
      rdata_ready_i = 1'b1;
      for (int t = 0; t < 8; t++) begin
         tick();
         settle();
         chk1("late_rsp_dropped", rdata_valid_o, 1'b0);
      end
      tick();
      rdata_ready_i = 1'b0;
      chk1("late_rsp_seen", (rvalid_cnt > base), 1'b1);
      chk1("late_q_drained", (rsp_q.size() == 0), 1'b1);

      // longest burst, written then read back
      lat_min = 1; lat_max = 3;
      do_write(32'h0000_8000, 256, 1'b0, 1'b0, 32'h0);
      do_read(32'h0000_8000, 256, 1'b1);

      // randomized bursts with random grants and consumer stalls
      gnt_mode = 1;
      last_wr_a = 32'h0000_1000; last_wr_n = 4;
      for (int k = 0; k < 14; k++) begin
         r = $urandom;
         a = {r[31:2], 2'b00};
         n = int'($urandom_range(1, 12));
         if (k == 3) a = 32'hFFFF_FFF0;
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, n, 1'b1, 1'b0, 32'h0);
            last_wr_a = a; last_wr_n = n;
         end else begin
            if ($urandom_range(0, 1) == 1) begin
               a = last_wr_a; n = last_wr_n;
            end
            do_read(a, n, 1'b1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
